// File: rtl/if_id_pipe_pkg.sv
// rtl/if_id_pipe_pkg.sv - shared constants and occupancy encoding for the IF/ID stage
package if_id_pipe_pkg;

   localparam logic                  RST_ENABLE   = 1'b1;
   localparam int                    ADDR_W_DEF   = 32;
   localparam int                    INST_W_DEF   = 32;
   localparam logic [31:0]           ZERO_WORD    = 32'h0000_0000;
   localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = '0;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - valid/ready register slice with flush and optional one-entry skid
module pipe_skid_reg
   import if_id_pipe_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter bit SKID_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   occ_e             state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             ready_q, ready_d;
   logic             fire_in;
   logic             fire_out;

   assign out_valid = (state_q != OCC_EMPTY);
   assign out_data  = main_q;
   assign fire_out  = out_valid & out_ready;
   // Skid mode exposes only the flop; single-entry mode lets a departing beat make room.
   assign in_ready  = SKID_EN ? ready_q : (~out_valid | fire_out);
   assign fire_in   = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = OCC_EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         case (state_q)
            OCC_EMPTY: begin
               if (fire_in) begin
                  state_d = OCC_ONE;
                  main_d  = in_data;
               end
            end
            OCC_ONE: begin
               if (fire_in && fire_out) begin
                  main_d = in_data;
               end else if (fire_in) begin
                  state_d = OCC_FULL;
                  skid_d  = in_data;
               end else if (fire_out) begin
                  state_d = OCC_EMPTY;
                  main_d  = '0;
               end
            end
            OCC_FULL: begin
               if (fire_out) begin
                  state_d = OCC_ONE;
                  main_d  = skid_q;
                  skid_d  = '0;
               end
            end
            default: begin
               state_d = OCC_EMPTY;
               main_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
      ready_d = (state_d != OCC_FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state_q <= OCC_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

endmodule

// File: rtl/if_id_pipe.sv
// rtl/if_id_pipe.sv - IF/ID pipeline register with handshake, stall, flush and bubble counter
module if_id_pipe
   import if_id_pipe_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INST_W   = INST_W_DEF,
   parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}},
   parameter bit                SKID_EN  = 1'b1,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              stall,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_pc,
   input  logic [INST_W-1:0] if_inst,
   output logic              if_ready,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   input  logic              id_ready,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam int DW = ADDR_W + INST_W;

   logic [DW-1:0]    slot_data;
   logic             slot_valid;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   pipe_skid_reg #(
      .WIDTH   (DW),
      .SKID_EN (SKID_EN)
   ) u_slot (
      .clk       (clk),
      .rst       (rst_n),
      .flush     (flush),
      .in_valid  (if_valid),
      .in_data   ({if_pc, if_inst}),
      .in_ready  (if_ready),
      .out_valid (slot_valid),
      .out_data  (slot_data),
      .out_ready (id_ready & ~stall)
   );

   // The slice zeroes its data when empty; NOP_INST may be non-zero, so force it here.
   assign id_valid = slot_valid;
   assign id_pc    = slot_valid ? slot_data[DW-1 -: ADDR_W] : ADDR_W'(ZERO_WORD);
   assign id_inst  = slot_valid ? slot_data[INST_W-1:0]     : NOP_INST;

   always_comb begin
      cnt_d = cnt_q;
      if (id_ready && !stall && !slot_valid && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n == RST_ENABLE) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// tb/tb_if_id_pipe.sv - scoreboard bench for if_id_pipe in skid and single-entry builds
module tb_if_id_pipe;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic        rst_n;
   logic        a_flush, a_stall, a_if_valid, a_id_ready;
   logic [31:0] a_if_pc, a_if_inst;
   logic        a_if_ready, a_id_valid;
   logic [31:0] a_id_pc, a_id_inst;
   logic [3:0]  a_bubble;

   logic        b_flush, b_stall, b_if_valid, b_id_ready;
   logic [31:0] b_if_pc, b_if_inst;
   logic        b_if_ready, b_id_valid;
   logic [31:0] b_id_pc, b_id_inst;
   logic [15:0] b_bubble;

   logic [63:0] exp_a[$];
   logic [63:0] exp_b[$];

   if_id_pipe #(.NOP_INST(NOP), .SKID_EN(1'b1), .CNT_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush), .stall(a_stall),
      .if_valid(a_if_valid), .if_pc(a_if_pc), .if_inst(a_if_inst), .if_ready(a_if_ready),
      .id_valid(a_id_valid), .id_pc(a_id_pc), .id_inst(a_id_inst), .id_ready(a_id_ready),
      .bubble_cnt(a_bubble)
   );

   if_id_pipe #(.NOP_INST(NOP), .SKID_EN(1'b0), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush), .stall(b_stall),
      .if_valid(b_if_valid), .if_pc(b_if_pc), .if_inst(b_if_inst), .if_ready(b_if_ready),
      .id_valid(b_id_valid), .id_pc(b_id_pc), .id_inst(b_id_inst), .id_ready(b_id_ready),
      .bubble_cnt(b_bubble)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hC0DE_0000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_drive(input logic [31:0] pc, input bit expect_out);
      a_if_valid = 1'b1;
      a_if_pc    = pc;
      a_if_inst  = inst_of(pc);
      if (expect_out) exp_a.push_back({pc, inst_of(pc)});
   endtask

   always @(negedge clk) begin : mon_a
      logic [63:0] e;
      if (rst_n == 1'b0 && !a_flush && a_id_valid && a_id_ready && !a_stall) begin
         if (exp_a.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a_unexpected_beat: got pc %h required no beat", a_id_pc);
         end else begin
            e = exp_a.pop_front();
            check("a_beat_pc", a_id_pc, e[63:32]);
            check("a_beat_inst", a_id_inst, e[31:0]);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      logic [63:0] e;
      if (rst_n == 1'b0 && !b_flush && b_id_valid && b_id_ready && !b_stall) begin
         if (exp_b.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b_unexpected_beat: got pc %h required no beat", b_id_pc);
         end else begin
            e = exp_b.pop_front();
            check("b_beat_pc", b_id_pc, e[63:32]);
            check("b_beat_inst", b_id_inst, e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1;
      a_flush = 0; a_stall = 0; a_if_valid = 0; a_id_ready = 0; a_if_pc = 0; a_if_inst = 0;
      b_flush = 0; b_stall = 0; b_if_valid = 0; b_id_ready = 0; b_if_pc = 0; b_if_inst = 0;
      repeat (2) tick();

      check("rst_id_valid", {31'd0, a_id_valid}, 32'd0);
      check("rst_id_pc", a_id_pc, 32'd0);
      check("rst_id_inst", a_id_inst, NOP);
      check("rst_if_ready", {31'd0, a_if_ready}, 32'd1);
      check("rst_bubble", {28'd0, a_bubble}, 32'd0);

      rst_n = 1'b0;
      a_id_ready = 1'b1;
      repeat (3) tick();
      check("bubble_count_3", {28'd0, a_bubble}, 32'd3);

      // streaming: one beat per cycle, one cycle latency
      for (int i = 0; i < 3; i++) begin
         a_drive(32'h100 + 32'(4 * i), 1'b1);
         tick();
         check("stream_valid", {31'd0, a_id_valid}, 32'd1);
         check("stream_pc", a_id_pc, 32'h100 + 32'(4 * i));
      end
      a_if_valid = 1'b0;
      tick();
      check("drain_valid", {31'd0, a_id_valid}, 32'd0);
      check("drain_inst_nop", a_id_inst, NOP);
      check("drain_pc_zero", a_id_pc, 32'd0);

      // backpressure into the skid entry
      a_id_ready = 1'b0;
      a_drive(32'h200, 1'b1);
      tick();
      a_stall = 1'b1;
      a_id_ready = 1'b1;
      a_drive(32'h204, 1'b1);
      tick();
      a_if_valid = 1'b0;
      check("bp_full_if_ready", {31'd0, a_if_ready}, 32'd0);
      check("bp_hold_pc", a_id_pc, 32'h200);
      tick();
      check("bp_hold_pc2", a_id_pc, 32'h200);
      check("bp_hold_valid", {31'd0, a_id_valid}, 32'd1);
      a_stall = 1'b0;
      tick();
      check("bp_second_pc", a_id_pc, 32'h204);
      check("bp_ready_back", {31'd0, a_if_ready}, 32'd1);
      tick();
      check("bp_empty", {31'd0, a_id_valid}, 32'd0);

      // flush while FULL with fetch presenting 0x300
      a_id_ready = 1'b0;
      a_drive(32'h2A0, 1'b0);
      tick();
      a_drive(32'h2A4, 1'b0);
      tick();
      check("fl_full_if_ready", {31'd0, a_if_ready}, 32'd0);
      a_flush = 1'b1;
      a_drive(32'h300, 1'b0);
      tick();
      a_flush = 1'b0;
      a_if_valid = 1'b0;
      check("fl_valid", {31'd0, a_id_valid}, 32'd0);
      check("fl_inst_nop", a_id_inst, NOP);
      check("fl_pc_zero", a_id_pc, 32'd0);
      check("fl_if_ready", {31'd0, a_if_ready}, 32'd1);

      // flush beats stall while a real beat 0x310 is accepted
      a_drive(32'h2B0, 1'b0);
      tick();
      a_stall = 1'b1;
      a_id_ready = 1'b1;
      a_flush = 1'b1;
      a_drive(32'h310, 1'b0);
      tick();
      a_flush = 1'b0;
      a_stall = 1'b0;
      a_if_valid = 1'b0;
      check("fls_valid", {31'd0, a_id_valid}, 32'd0);
      check("fls_if_ready", {31'd0, a_if_ready}, 32'd1);
      repeat (3) tick();
      check("fls_still_empty", {31'd0, a_id_valid}, 32'd0);

      // asynchronous reset while FULL
      a_id_ready = 1'b0;
      a_drive(32'h400, 1'b0);
      tick();
      a_drive(32'h404, 1'b0);
      tick();
      a_if_valid = 1'b0;
      check("ar_full", {31'd0, a_if_ready}, 32'd0);
      #2;
      rst_n = 1'b1;
      #1;
      check("ar_valid", {31'd0, a_id_valid}, 32'd0);
      check("ar_pc", a_id_pc, 32'd0);
      check("ar_inst", a_id_inst, NOP);
      check("ar_if_ready", {31'd0, a_if_ready}, 32'd1);
      check("ar_bubble", {28'd0, a_bubble}, 32'd0);
      tick();
      rst_n = 1'b0;

      // starvation counter saturates at 4'hF
      a_id_ready = 1'b1;
      repeat (14) tick();
      check("sat_14", {28'd0, a_bubble}, 32'd14);
      repeat (6) tick();
      check("sat_hold", {28'd0, a_bubble}, 32'hF);
      check("a_queue_empty", 32'(exp_a.size()), 32'd0);

      // single-entry build
      b_id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b_if_valid = 1'b1;
         b_if_pc    = 32'h600 + 32'(4 * i);
         b_if_inst  = inst_of(b_if_pc);
         exp_b.push_back({b_if_pc, b_if_inst});
         tick();
         check("b_stream_valid", {31'd0, b_id_valid}, 32'd1);
         check("b_stream_pc", b_id_pc, 32'h600 + 32'(4 * i));
         check("b_stream_ready", {31'd0, b_if_ready}, 32'd1);
      end
      b_if_valid = 1'b0;
      tick();
      b_id_ready = 1'b0;
      b_if_valid = 1'b1;
      b_if_pc    = 32'h700;
      b_if_inst  = inst_of(32'h700);
      exp_b.push_back({32'h700, inst_of(32'h700)});
      tick();
      b_if_valid = 1'b0;
      check("b_ready_low", {31'd0, b_if_ready}, 32'd0);
      b_id_ready = 1'b1;
      #1;
      check("b_ready_follows_hi", {31'd0, b_if_ready}, 32'd1);
      b_id_ready = 1'b0;
      #1;
      check("b_ready_follows_lo", {31'd0, b_if_ready}, 32'd0);
      b_id_ready = 1'b1;
      tick();
      check("b_drained", {31'd0, b_id_valid}, 32'd0);
      check("b_drain_inst_nop", b_id_inst, NOP);
      check("b_queue_empty", 32'(exp_b.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
